keypad_scan_debounce: RTL

Debounced 4x4 matrix-keypad front end. It drives the one-hot column scan, samples the row lines through a synchroniser, and turns a stable press into one `key_code`/`key_valid` event per press. It sits directly upstream of the seven-segment display stage, which consumes `key_code` on `key_valid` instead of decoding raw row/column state itself.

---
 rtl/keypad_scan_debounce.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/keypad_scan_debounce.sv
// 4x4 keypad column scanner with row synchroniser and per-scan debounce.
// Optional auto-repeat while held: define KEYPAD_REPEAT_EN.
module keypad_scan_debounce #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [3:0] DS = 4'(DEBOUNCE_SCANS);

  if (SCAN_DIV < 4) begin : g_bad_div
    $error("SCAN_DIV must be >= 4");
  end
  if (DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15) begin : g_bad_db
    $error("DEBOUNCE_SCANS must be 1..15");
  end
  if (REPEAT_SCANS < 1 || REPEAT_SCANS > 255) begin : g_bad_rep
    $error("REPEAT_SCANS must be 1..255");
  end

  typedef enum logic [1:0] {
    IDLE, PRESS_CHK, HELD, RELEASE_CHK
  } state_t;

  logic [3:0]    sync1, sync2;
  logic [DW-1:0] dwell;
  logic [1:0]    col_idx;
  logic          acc_hit;
  logic [3:0]    acc_code;
  logic          sample, eval;
  logic          cur_hit;
  logic [1:0]    cur_row;
  logic          scan_hit;
  logic [3:0]    scan_code;

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n, cnt_inc;
  logic [3:0] cand, cand_n;
  logic [3:0] code_n;
  logic       valid_n;
`ifdef KEYPAD_REPEAT_EN
  logic [7:0] rep, rep_n, rep_inc;
`endif

  assign col      = 4'b0001 << col_idx;
  assign sample   = (dwell == DW'(SCAN_DIV - 1));
  assign eval     = sample && (col_idx == 2'd3);
  assign key_held = (state == HELD) || (state == RELEASE_CHK);
  assign cnt_inc  = cnt + 4'd1;

  // Two-flop synchroniser for the asynchronous row lines.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 4'h0;
      sync2 <= 4'h0;
    end else begin
      sync1 <= row;
      sync2 <= sync1;
    end
  end

  // Lowest set row bit wins within a column.
  always_comb begin
    cur_hit = |sync2;
    cur_row = 2'd0;
    if (sync2[0])      cur_row = 2'd0;
    else if (sync2[1]) cur_row = 2'd1;
    else if (sync2[2]) cur_row = 2'd2;
    else if (sync2[3]) cur_row = 2'd3;
  end

  // Whole-scan result: first hit in column order, including column 3.
  always_comb begin
    scan_hit  = acc_hit || cur_hit;
    scan_code = acc_hit ? acc_code : {cur_row, 2'd3};
  end

  // Dwell counter, column rotation and per-scan hit accumulation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dwell    <= '0;
      col_idx  <= 2'd0;
      acc_hit  <= 1'b0;
      acc_code <= 4'h0;
    end else if (sample) begin
      dwell   <= '0;
      col_idx <= col_idx + 2'd1;
      if (col_idx == 2'd3) begin
        acc_hit  <= 1'b0;
        acc_code <= 4'h0;
      end else if (!acc_hit && cur_hit) begin
        acc_hit  <= 1'b1;
        acc_code <= {cur_row, col_idx};
      end
    end else begin
      dwell <= dwell + DW'(1);
    end
  end

  // Debounce next-state and event logic, evaluated once per scan.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cand_n  = cand;
    code_n  = key_code;
    valid_n = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_n   = rep;
    rep_inc = rep + 8'd1;
`endif
    if (eval) begin
      unique case (state)
        IDLE: begin
          if (scan_hit) begin
            cand_n = scan_code;
            cnt_n  = 4'd1;
            if (DS == 4'd1) begin
              code_n  = scan_code;
              valid_n = 1'b1;
              state_n = HELD;
`ifdef KEYPAD_REPEAT_EN
              rep_n   = 8'd0;
`endif
            end else begin
              state_n = PRESS_CHK;
            end
          end
        end
        PRESS_CHK: begin
          if (!scan_hit) begin
            state_n = IDLE;
          end else if (scan_code == cand) begin
            cnt_n = cnt_inc;
            if (cnt_inc == DS) begin
              code_n  = cand;
              valid_n = 1'b1;
              state_n = HELD;
`ifdef KEYPAD_REPEAT_EN
              rep_n   = 8'd0;
`endif
            end
          end else begin
            cand_n = scan_code;
            cnt_n  = 4'd1;
          end
        end
        HELD: begin
          if (!scan_hit) begin
            cnt_n   = 4'd1;
            state_n = (DS == 4'd1) ? IDLE : RELEASE_CHK;
`ifdef KEYPAD_REPEAT_EN
            rep_n   = 8'd0;
`endif
          end else begin
`ifdef KEYPAD_REPEAT_EN
            if (rep_inc == 8'(REPEAT_SCANS)) begin
              rep_n   = 8'd0;
              valid_n = 1'b1;
            end else begin
              rep_n = rep_inc;
            end
`endif
          end
        end
        RELEASE_CHK: begin
          if (scan_hit) begin
            state_n = HELD;
`ifdef KEYPAD_REPEAT_EN
            rep_n   = 8'd0;
`endif
          end else begin
            cnt_n = cnt_inc;
            if (cnt_inc == DS) state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Debounce state and registered event outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      cand      <= 4'h0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep       <= 8'd0;
`endif
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      cand      <= cand_n;
      key_code  <= code_n;
      key_valid <= valid_n;
`ifdef KEYPAD_REPEAT_EN
      rep       <= rep_n;
`endif
    end
  end

endmodule
